// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, frame size and 50 MHz timing defaults for the PS/2 host transmitter.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_state_e;
    localparam int FRAME_BITS         = 10;
    localparam int INHIBIT_CYCLES_DEF = 5000;
    localparam int REQ_CYCLES_DEF     = 50;
    localparam int TIMEOUT_CYCLES_DEF = 750000;
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request handshake and status between the MMIO port and the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer with a one-cycle falling-edge pulse.
module ps2_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic din_i,
    output logic sync_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;
    // Idle PS/2 lines float high, so resetting to 1 avoids a false edge.
    always_ff @(posedge clock) begin
        if (!resetn) {meta_q, sync_q, prev_q} <= 3'b111;
        else {meta_q, sync_q, prev_q} <= {din_i, meta_q, sync_q};
    end
    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving the pads through open-drain enables.
// Define PS2_TX_ACK_CHECK_EN to report a device nack as tx_error instead of tx_done.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int REQ_CYCLES     = REQ_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         clock,
    input  logic         resetn,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif
    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] REQ_LAST = 20'(REQ_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
    ps2_state_e            state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [3:0]            bitcnt_q;
    logic [19:0]           cnt_q;
    logic                  nack_q, clk_oe_q, data_oe_q, done_q, err_q;
    logic                  clk_s, clk_fall, data_meta_q, data_s_q;
    ps2_sync_edge u_clk_sync (
        .clock  (clock),
        .resetn (resetn),
        .din_i  (ps2_clk_in),
        .sync_o (clk_s),
        .fall_o (clk_fall)
    );
    always_ff @(posedge clock) begin
        if (!resetn) {data_meta_q, data_s_q} <= 2'b11;
        else {data_meta_q, data_s_q} <= {ps2_data_in, data_meta_q};
    end
    // cnt_q times the inhibit/request phases, then doubles as the transaction timeout.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: if (tx.tx_valid && !done_q && !err_q) begin
                    frame_q  <= make_frame(tx.tx_data);
                    bitcnt_q <= '0;
                    cnt_q    <= '0;
                    clk_oe_q <= 1'b1;
                    state_q  <= INHIBIT;
                end
                INHIBIT: if (cnt_q == INH_LAST) begin
                    cnt_q     <= '0;
                    data_oe_q <= 1'b1;
                    state_q   <= REQ;
                end else cnt_q <= cnt_q + 20'd1;
                REQ: if (cnt_q == REQ_LAST) begin
                    cnt_q    <= '0;
                    clk_oe_q <= 1'b0;
                    state_q  <= SHIFT;
                end else cnt_q <= cnt_q + 20'd1;
                SHIFT: if (clk_fall) begin
                    data_oe_q <= ~frame_q[bitcnt_q];
                    bitcnt_q  <= bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) state_q <= ACK;
                end
                ACK: begin
                    data_oe_q <= 1'b0;
                    if (clk_fall) begin
                        nack_q  <= data_s_q;
                        state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: if (clk_s && data_s_q) begin
                    done_q  <= ~(ACK_CHECK & nack_q);
                    err_q   <= ACK_CHECK & nack_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
                if (cnt_q == TO_LAST) begin
                    state_q   <= IDLE;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b1;
                    cnt_q     <= '0;
                end else cnt_q <= cnt_q + 20'd1;
            end
        end
    end
    // Ready stays low during the completion pulse so the next byte lands one cycle later.
    assign tx.tx_ready  = (state_q == IDLE) && !done_q && !err_q;
    assign tx.busy      = state_q != IDLE;
    assign tx.tx_done   = done_q;
    assign tx.tx_error  = err_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model and a cycle timeline model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int REQ = 8;
    localparam int TO  = 1500;
    localparam int H   = 15;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic ps2_clk_oe, ps2_data_oe, pad_clk, pad_data;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
    bit   dev_silent = 1'b0, dev_ack_low = 1'b1, dev_rel = 1'b0;
    int   n_tests = 0, n_fail = 0;
    bit   m_busy = 1'b0, m_to = 1'b0, m_nack = 1'b0, rst_pend = 1'b0;
    int   m_t = 0, rel_n = 0, done_cnt = 0, err_cnt = 0;

    ps2_host_tx_if tx ();
    assign pad_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign pad_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx          (tx),
        .ps2_clk_in  (pad_clk),
        .ps2_data_in (pad_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clock = ~clock;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: fixed inhibit/request phases, idle lines in SHIFT, one pulse a few cycles after the bus goes idle.
    task automatic compare_step();
        bit pulse, ended;
        logic [5:0] idle_v;
        if (!resetn) begin
            rst_pend = 1'b1;
            return;
        end
        ended = 1'b0;
        pulse = tx.tx_done | tx.tx_error;
        rel_n = dev_rel ? rel_n + 1 : 0;
        idle_v = {tx.tx_ready, tx.busy, ps2_clk_oe, ps2_data_oe, tx.tx_done, tx.tx_error};
        chk(!(tx.tx_done && tx.tx_error), "pulse_exclusive", {tx.tx_done, tx.tx_error}, 0);
        if (rst_pend) begin
            chk(idle_v == 6'b100000, "reset_state", idle_v, 6'b100000);
            rst_pend = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_t++;
            if (pulse) begin
                chk(tx.tx_error == (m_to || (ACK_CHECK && m_nack)), "end_kind", tx.tx_error,
                    m_to || (ACK_CHECK && m_nack));
                if (m_to) chk(m_t == INH + REQ + TO + 1, "timeout_time", m_t, INH + REQ + TO + 1);
                else chk(rel_n >= 3 && rel_n <= 5, "end_time", rel_n, 4);
                chk(idle_v[5:2] == 4'b0000, "end_outputs", idle_v[5:2], 0);
                done_cnt += tx.tx_done;
                err_cnt += tx.tx_error;
                m_busy = 1'b0;
                ended = 1'b1;
            end else begin
                chk(idle_v[5:3] == {2'b01, m_t <= INH + REQ}, "busy_timeline", idle_v[5:3],
                    {2'b01, m_t <= INH + REQ});
                if (m_t <= INH + REQ)
                    chk(ps2_data_oe == (m_t > INH), "data_timeline", ps2_data_oe, m_t > INH);
                else if (m_to)
                    chk(ps2_data_oe == 1'b1, "silent_hold", ps2_data_oe, 1);
                if (m_t > INH + REQ + TO) begin
                    chk(1'b0, "overdue", m_t, INH + REQ + TO + 1);
                    m_busy = 1'b0;
                end
            end
        end else begin
            chk(idle_v == 6'b100000, "idle_outputs", idle_v, 6'b100000);
        end
        if (!m_busy && !ended && tx.tx_valid) begin
            m_busy = 1'b1;
            m_t = 0;
            m_to = dev_silent;
            m_nack = !dev_ack_low;
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx.tx_data = b;
        tx.tx_valid = 1'b1;
        dev_rel = 1'b0;
        @(posedge clock); #1;
        tx.tx_valid = 1'b0;
    endtask

    // Device: wait for request-to-send, clock nfalls pulses, sample data after each rising edge.
    task automatic dev_frame(input int nfalls, output logic [10:0] bits);
        int n = 0;
        bits = '0;
        while (!(pad_clk && !pad_data) && n < INH + REQ + 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk(n < INH + REQ + 100, "request_seen", n, INH + REQ + 1);
        repeat (H) @(posedge clock);
        #1;
        bits[0] = pad_data;
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && dev_ack_low) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(posedge clock);
                #1;
            end
            dev_clk_low = 1'b1;
            repeat (H) @(posedge clock);
            #1;
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = pad_data;
            if (k == 11) begin
                if (dev_ack_low) begin
                    repeat (H / 2) @(posedge clock);
                    #1;
                    dev_data_low = 1'b0;
                end
                dev_rel = 1'b1;
            end else begin
                repeat (H) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic wait_end(input int bound, output bit got_err);
        int s = done_cnt + err_cnt;
        int e0 = err_cnt;
        int n = 0;
        while (done_cnt + err_cnt == s && n < bound) begin
            @(posedge clock); #1;
            n++;
        end
        chk(n < bound, "end_seen", n, bound);
        got_err = err_cnt != e0;
    endtask

    task automatic chk_frame(input logic [7:0] b, input logic [10:0] bits, input string name);
        logic [10:0] exp;
        exp = {1'b1, ($countones(b) % 2) == 0, b, 1'b0};
        chk(bits == exp, name, bits, exp);
    endtask

    initial begin
        logic [10:0] bits;
        bit e;
        int d0, hits;
        tx.tx_data = '0;
        tx.tx_valid = 1'b0;
        fork
            forever begin
                @(negedge clock);
                compare_step();
            end
        join_none
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        // 0xED with ack
        send(8'hED);
        dev_frame(11, bits);
        chk(bits == 11'b11111011010, "ed_bits_literal", bits, 11'b11111011010);
        chk_frame(8'hED, bits, "ed_frame");
        wait_end(20, e);
        chk(!e, "ed_done", e, 0);
        chk(tx.tx_ready == 1'b1, "ed_ready", tx.tx_ready, 1);
        repeat (5) @(posedge clock);
        #1;
        // 0xF4 with an ignored request while busy
        send(8'hF4);
        repeat (10) @(posedge clock);
        #1;
        tx.tx_data = 8'h00;
        tx.tx_valid = 1'b1;
        @(posedge clock); #1;
        tx.tx_valid = 1'b0;
        dev_frame(11, bits);
        chk(bits == 11'b10111101000, "f4_bits_literal", bits, 11'b10111101000);
        chk_frame(8'hF4, bits, "f4_frame");
        wait_end(20, e);
        chk(!e, "f4_done", e, 0);
        hits = 0;
        repeat (INH + REQ + 20) begin
            @(posedge clock); #1;
            hits += ps2_clk_oe;
        end
        chk(hits == 0, "f4_single_frame", hits, 0);
        // Device never clocks
        dev_silent = 1'b1;
        d0 = done_cnt;
        send(8'h55);
        wait_end(INH + REQ + TO + 50, e);
        chk(e, "timeout_error", e, 1);
        chk(done_cnt == d0, "timeout_no_done", done_cnt, d0);
        chk({ps2_clk_oe, ps2_data_oe} == 2'b00, "timeout_released", {ps2_clk_oe, ps2_data_oe}, 0);
        dev_silent = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        // Device answers nack
        dev_ack_low = 1'b0;
        send(8'h3C);
        dev_frame(11, bits);
        chk_frame(8'h3C, bits, "nack_frame");
        wait_end(20, e);
        chk(e == ACK_CHECK, "nack_kind", e, ACK_CHECK);
        dev_ack_low = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        // Reset after the fourth edge in SHIFT, then 0xFF
        send(8'hA5);
        dev_frame(4, bits);
        chk(bits[4:0] == 5'b01010, "a5_partial_bits", bits[4:0], 5'b01010);
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        chk({tx.tx_ready, ps2_clk_oe, ps2_data_oe, tx.tx_done, tx.tx_error} == 5'b10000, "midreset_state",
            {tx.tx_ready, ps2_clk_oe, ps2_data_oe, tx.tx_done, tx.tx_error}, 5'b10000);
        repeat (3) @(posedge clock);
        #1;
        send(8'hFF);
        dev_frame(11, bits);
        chk(bits == 11'b11111111110, "ff_bits_literal", bits, 11'b11111111110);
        wait_end(20, e);
        chk(!e, "ff_done", e, 0);
        repeat (5) @(posedge clock);
        #1;
        // Back-to-back 0xED then 0x07
        d0 = done_cnt;
        send(8'hED);
        dev_frame(11, bits);
        chk_frame(8'hED, bits, "b2b_ed_frame");
        wait_end(20, e);
        chk(tx.tx_ready == 1'b1, "b2b_ready", tx.tx_ready, 1);
        send(8'h07);
        dev_frame(11, bits);
        chk(bits == 11'b10000001110, "b2b_07_bits_literal", bits, 11'b10000001110);
        wait_end(20, e);
        chk(done_cnt == d0 + 2, "b2b_two_done", done_cnt, d0 + 2);
        repeat (10) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
